// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default widths for the fetch/load-store bus arbiter.
// Latency: n/a (declarations only). Backpressure: n/a.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    REQ_IF,
    REQ_MEM,
    RSP_IF,
    RSP_MEM
  } arb_state_t;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and load/store; round-robin under MEM_BUS_ARB_RR_EN.
// Latency: combinational grant. Backpressure: a killed fetch never wins a grant.
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
(
`ifdef MEM_BUS_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic take,
`endif
  input  logic if_req,
  input  logic if_kill,
  input  logic mem_req,
  output logic gnt_if,
  output logic gnt_mem
);

  logic if_ok;
  assign if_ok = if_req && !if_kill;

`ifdef MEM_BUS_ARB_RR_EN
  grant_t last_q;

  // Only grants actually taken in IDLE move the fairness pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_IF;
    end else if (take && gnt_mem) begin
      last_q <= GNT_MEM;
    end else if (take && gnt_if) begin
      last_q <= GNT_IF;
    end
  end

  assign gnt_mem = mem_req && (!if_ok || (last_q == GNT_IF));
`else
  assign gnt_mem = mem_req;
`endif

  assign gnt_if = if_ok && !gnt_mem;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch and load/store onto one downstream bus, one transaction outstanding.
// Latency: 2 cycles minimum request-to-done. Backpressure: holds valid+payload until bus_ready_i.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                if_kill_i,
  output logic                if_done_o,
  output logic                if_stall_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_wstrb_i,
  output logic                mem_done_o,
  output logic                mem_stall_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                bus_valid_o,
  input  logic                bus_ready_i,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_wstrb_o,
  input  logic                bus_rvalid_i,
  input  logic [DATA_W-1:0]   bus_rdata_i
);

  arb_state_t state_q, state_d;
  logic       kill_q, kill_d;
  logic       gnt_if, gnt_mem;
  logic       in_idle;

  assign in_idle = (state_q == IDLE);

  mem_arb_pick u_pick (
`ifdef MEM_BUS_ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
    .take    (in_idle),
`endif
    .if_req  (if_req_i),
    .if_kill (if_kill_i),
    .mem_req (mem_req_i),
    .gnt_if  (gnt_if),
    .gnt_mem (gnt_mem)
  );

  always_comb begin
    state_d     = state_q;
    bus_valid_o = 1'b0;
    if_done_o   = 1'b0;
    mem_done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_mem) begin
          state_d = REQ_MEM;
        end else if (gnt_if) begin
          state_d = REQ_IF;
        end
      end
      REQ_IF: begin
        bus_valid_o = 1'b1;
        if (bus_ready_i) state_d = RSP_IF;
      end
      REQ_MEM: begin
        bus_valid_o = 1'b1;
        if (bus_ready_i) state_d = RSP_MEM;
      end
      RSP_IF: begin
        // A kill arriving in the response cycle itself also suppresses done.
        if_done_o = bus_rvalid_i && !kill_q && !if_kill_i;
        if (bus_rvalid_i) state_d = IDLE;
      end
      RSP_MEM: begin
        mem_done_o = bus_rvalid_i;
        if (bus_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      bus_valid_o = 1'b0;
      if_done_o   = 1'b0;
      mem_done_o  = 1'b0;
    end
  end

  always_comb begin
    kill_d = kill_q;
    if (state_d == IDLE) begin
      kill_d = 1'b0;
    end else if (((state_q == REQ_IF) || (state_q == RSP_IF)) && if_kill_i) begin
      kill_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      kill_q      <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_wstrb_o <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (in_idle && gnt_mem) begin
        bus_we_o    <= mem_we_i;
        bus_addr_o  <= mem_addr_i;
        bus_wdata_o <= mem_wdata_i;
        bus_wstrb_o <= mem_wstrb_i;
      end else if (in_idle && gnt_if) begin
        bus_we_o    <= 1'b0;
        bus_addr_o  <= if_addr_i;
        bus_wdata_o <= '0;
        bus_wstrb_o <= '0;
      end
    end
  end

  assign if_stall_o  = if_req_i && !if_done_o;
  assign mem_stall_o = mem_req_i && !mem_done_o;
  assign rdata_o     = bus_rdata_i;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change 1 ns after posedge, outputs checked 1 ns later.
module tb_mem_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic                if_req_i, if_kill_i, if_done_o, if_stall_o;
  logic [ADDR_W-1:0]   if_addr_i;
  logic                mem_req_i, mem_we_i, mem_done_o, mem_stall_o;
  logic [ADDR_W-1:0]   mem_addr_i;
  logic [DATA_W-1:0]   mem_wdata_i;
  logic [DATA_W/8-1:0] mem_wstrb_i;
  logic [DATA_W-1:0]   rdata_o;
  logic                bus_valid_o, bus_ready_i, bus_we_o, bus_rvalid_i;
  logic [ADDR_W-1:0]   bus_addr_o;
  logic [DATA_W-1:0]   bus_wdata_o, bus_rdata_i;
  logic [DATA_W/8-1:0] bus_wstrb_o;

  int checks = 0;
  int errors = 0;
  logic if_first;
  logic [ADDR_W-1:0] exp_addr;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
    .if_done_o(if_done_o), .if_stall_o(if_stall_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i),
    .mem_done_o(mem_done_o), .mem_stall_o(mem_stall_o),
    .rdata_o(rdata_o),
    .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_req_i = 0; if_addr_i = '0; if_kill_i = 0;
    mem_req_i = 0; mem_we_i = 0; mem_addr_i = '0; mem_wdata_i = '0; mem_wstrb_i = '0;
    bus_ready_i = 0; bus_rvalid_i = 0; bus_rdata_i = '0;
    tick; tick;
    rst = 1'b0;
    #1;
    chk("reset_valid", bus_valid_o, 0);
    chk("reset_if_done", if_done_o, 0);
    chk("reset_mem_done", mem_done_o, 0);

    // Minimum-latency fetch
    tick; if_req_i = 1; if_addr_i = 32'h8000_0000; #1;
    chk("f_c0_stall", if_stall_o, 1);
    chk("f_c0_valid", bus_valid_o, 0);
    tick; bus_ready_i = 1; bus_rvalid_i = 1; #1;
    chk("f_c1_valid", bus_valid_o, 1);
    chk("f_c1_addr", bus_addr_o, 32'h8000_0000);
    chk("f_c1_we", bus_we_o, 0);
    chk("f_c1_strb", bus_wstrb_o, 0);
    chk("f_c1_done_early", if_done_o, 0);
    chk("f_c1_stall", if_stall_o, 1);
    tick; bus_ready_i = 0; bus_rdata_i = 64'hCAFE_F00D_1234_5678; #1;
    chk("f_c2_done", if_done_o, 1);
    chk("f_c2_rdata", rdata_o, 64'hCAFE_F00D_1234_5678);
    chk("f_c2_stall", if_stall_o, 0);
    chk("f_c2_valid", bus_valid_o, 0);
    tick; if_req_i = 0; bus_rvalid_i = 0; #1;
    chk("f_c3_done", if_done_o, 0);
    chk("f_c3_valid", bus_valid_o, 0);

    // Kill in IDLE blocks the grant for that cycle only
    tick; if_req_i = 1; if_addr_i = 32'h0000_0040; if_kill_i = 1; #1;
    chk("ki_c0_valid", bus_valid_o, 0);
    tick; if_kill_i = 0; #1;
    chk("ki_c1_blocked", bus_valid_o, 0);
    tick; bus_ready_i = 1; #1;
    chk("ki_c2_valid", bus_valid_o, 1);
    tick; bus_ready_i = 0; bus_rvalid_i = 1; #1;
    chk("ki_c3_done", if_done_o, 1);
    tick; if_req_i = 0; bus_rvalid_i = 0;

    // Simultaneous requests: MEM store first, IF after the done cycle
    tick; if_req_i = 1; if_addr_i = 32'h0000_2000;
    mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h0000_1000;
    mem_wdata_i = 64'h1122_3344_5566_7788; mem_wstrb_i = 8'hFF; #1;
    chk("p_c0_if_stall", if_stall_o, 1);
    chk("p_c0_mem_stall", mem_stall_o, 1);
    tick; bus_ready_i = 1; #1;
    chk("p_c1_addr", bus_addr_o, 32'h0000_1000);
    chk("p_c1_we", bus_we_o, 1);
    chk("p_c1_strb", bus_wstrb_o, 8'hFF);
    chk("p_c1_wdata", bus_wdata_o, 64'h1122_3344_5566_7788);
    tick; bus_ready_i = 0; bus_rvalid_i = 1; #1;
    chk("p_c2_mem_done", mem_done_o, 1);
    chk("p_c2_if_done", if_done_o, 0);
    chk("p_c2_if_stall", if_stall_o, 1);
    tick; mem_req_i = 0; bus_rvalid_i = 0; #1;
    chk("p_c3_no_grant", bus_valid_o, 0);
    tick; bus_ready_i = 1; #1;
    chk("p_c4_valid", bus_valid_o, 1);
    chk("p_c4_addr", bus_addr_o, 32'h0000_2000);
    chk("p_c4_we", bus_we_o, 0);
    tick; bus_ready_i = 0; bus_rvalid_i = 1; #1;
    chk("p_c5_if_done", if_done_o, 1);
    tick; if_req_i = 0; bus_rvalid_i = 0;

    // Lone MEM store so that MEM is the last grant
    tick; mem_req_i = 1; mem_addr_i = 32'h0000_1100;
    tick; bus_ready_i = 1; #1;
    chk("l_addr", bus_addr_o, 32'h0000_1100);
    tick; bus_ready_i = 0; bus_rvalid_i = 1; #1;
    chk("l_done", mem_done_o, 1);
    tick; mem_req_i = 0; bus_rvalid_i = 0;

    // Second simultaneous pair
`ifdef MEM_BUS_ARB_RR_EN
    if_first = 1'b1;
`else
    if_first = 1'b0;
`endif
    tick; if_req_i = 1; if_addr_i = 32'h0000_2200; mem_req_i = 1; mem_addr_i = 32'h0000_1200;
    tick; bus_ready_i = 1; #1;
    exp_addr = if_first ? 32'h0000_2200 : 32'h0000_1200;
    chk("p2_first_addr", bus_addr_o, exp_addr);
    chk("p2_first_we", bus_we_o, !if_first);
    tick; bus_ready_i = 0; bus_rvalid_i = 1; #1;
    chk("p2_first_if_done", if_done_o, if_first);
    chk("p2_first_mem_done", mem_done_o, !if_first);
    tick; bus_rvalid_i = 0;
    if (if_first) if_req_i = 0; else mem_req_i = 0;
    tick; bus_ready_i = 1; #1;
    exp_addr = if_first ? 32'h0000_1200 : 32'h0000_2200;
    chk("p2_second_addr", bus_addr_o, exp_addr);
    tick; bus_ready_i = 0; bus_rvalid_i = 1; #1;
    chk("p2_second_if_done", if_done_o, !if_first);
    chk("p2_second_mem_done", mem_done_o, if_first);
    tick; if_req_i = 0; mem_req_i = 0; bus_rvalid_i = 0;

    // Downstream not ready for 5 cycles; stray rvalid must be ignored
    tick; if_req_i = 1; if_addr_i = 32'h0000_3300;
    mem_req_i = 1; mem_addr_i = 32'h0000_4400; mem_wdata_i = 64'hA5A5_0000_FFFF_5A5A; mem_wstrb_i = 8'h0F;
    bus_rvalid_i = 1;
    for (int i = 0; i < 5; i++) begin
      tick; #1;
      chk("h_valid", bus_valid_o, 1);
      chk("h_addr", bus_addr_o, 32'h0000_4400);
      chk("h_wdata", bus_wdata_o, 64'hA5A5_0000_FFFF_5A5A);
      chk("h_strb", bus_wstrb_o, 8'h0F);
      chk("h_if_stall", if_stall_o, 1);
      chk("h_mem_stall", mem_stall_o, 1);
      chk("h_mem_done", mem_done_o, 0);
    end
    tick; bus_ready_i = 1; bus_rvalid_i = 0; #1;
    chk("h_valid_last", bus_valid_o, 1);
    tick; bus_ready_i = 0; bus_rvalid_i = 1; #1;
    chk("h_mem_done_pulse", mem_done_o, 1);
    chk("h_mem_stall_low", mem_stall_o, 0);
    tick; mem_req_i = 0; bus_rvalid_i = 0;
    tick; bus_ready_i = 1; #1;
    chk("h_if_addr", bus_addr_o, 32'h0000_3300);
    tick; bus_ready_i = 0; bus_rvalid_i = 1; #1;
    chk("h_if_done", if_done_o, 1);
    tick; if_req_i = 0; bus_rvalid_i = 0;

    // Kill during RSP_IF
    tick; if_req_i = 1; if_addr_i = 32'h0000_5500;
    tick; bus_ready_i = 1;
    tick; bus_ready_i = 0; if_kill_i = 1; #1;
    chk("k_c2_done", if_done_o, 0);
    tick; if_kill_i = 0; bus_rvalid_i = 1; if_req_i = 0;
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h0000_6600; #1;
    chk("k_c3_done_suppressed", if_done_o, 0);
    chk("k_c3_mem_stall", mem_stall_o, 1);
    tick; bus_rvalid_i = 0; #1;
    chk("k_c4_idle", bus_valid_o, 0);
    tick; bus_ready_i = 1; #1;
    chk("k_c5_valid", bus_valid_o, 1);
    chk("k_c5_addr", bus_addr_o, 32'h0000_6600);
    chk("k_c5_we", bus_we_o, 0);
    tick; bus_ready_i = 0; bus_rvalid_i = 1; bus_rdata_i = 64'h0BAD_BEEF_0000_0001; #1;
    chk("k_c6_mem_done", mem_done_o, 1);
    chk("k_c6_rdata", rdata_o, 64'h0BAD_BEEF_0000_0001);
    tick; mem_req_i = 0; bus_rvalid_i = 0;

    // Reset in RSP_MEM abandons the transaction
    tick; mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h0000_7700;
    tick; bus_ready_i = 1;
    tick; bus_ready_i = 0; rst = 1; bus_rvalid_i = 1; mem_req_i = 0; #1;
    chk("r_c2_done", mem_done_o, 0);
    chk("r_c2_valid", bus_valid_o, 0);
    tick; rst = 0; #1;
    chk("r_c3_late_rvalid", mem_done_o, 0);
    chk("r_c3_valid", bus_valid_o, 0);
    tick; bus_rvalid_i = 0; #1;
    chk("r_c4_valid", bus_valid_o, 0);
    chk("r_c4_mem_stall", mem_stall_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
